// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache in front of the instruction ROM.
// Hits return data combinationally; misses stall and fill over the ROM handshake.
module icache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_ce_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        stallreq,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  input  logic        rom_data_ready
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [31:0]           miss_addr_q, miss_addr_d;
  logic [31:0]           rom_addr_q, rom_addr_d;
  logic                  rom_ce_q, rom_ce_d;
  logic [TAG_BITS-1:0]   tag_ram_q  [LINES];
  logic [31:0]           data_ram_q [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  fill_we;
  logic                  unused_bits;

  assign idx         = pc_i[INDEX_BITS+1:2];
  assign tag         = pc_i[31:INDEX_BITS+2];
  assign fill_idx    = miss_addr_q[INDEX_BITS+1:2];
  assign hit         = pc_ce_i && valid_q[idx] && (tag_ram_q[idx] == tag) && (state_q == IDLE);
  assign unused_bits = ^{pc_i[1:0], miss_addr_q[1:0]};

  assign rom_addr_o  = rom_addr_q;
  assign rom_ce_o    = rom_ce_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    rom_addr_d  = rom_addr_q;
    rom_ce_d    = rom_ce_q;
    fill_we     = 1'b0;
    stallreq    = 1'b0;
    inst_o      = '0;
    case (state_q)
      IDLE: begin
        if (pc_ce_i) begin
          if (hit) begin
            inst_o = data_ram_q[idx];
          end else begin
            stallreq    = 1'b1;
            miss_addr_d = {pc_i[31:2], 2'b00};
            rom_addr_d  = {pc_i[31:2], 2'b00};
            rom_ce_d    = 1'b1;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        stallreq = 1'b1;
        if (rom_data_ready) begin
          fill_we           = !rst;
          valid_d[fill_idx] = 1'b1;
          rom_ce_d          = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush is applied last so it wins over a fill landing on the same edge.
    if (flush_i) valid_d = '0;
    if (rst) begin
      inst_o   = '0;
      stallreq = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      rom_addr_q  <= '0;
      rom_ce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      rom_addr_q  <= rom_addr_d;
      rom_ce_q    <= rom_ce_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_ram_q[fill_idx] <= rom_data_i;
      tag_ram_q[fill_idx]  <= miss_addr_q[31:INDEX_BITS+2];
    end
  end

endmodule
